stream_pkt_arbiter: RTL and testbench
=====================================

STREAM_PKT_ARBITER -- requirements
Module: stream_pkt_arbiter

Interface
REQ-001: Parameter DATA_W, default 32: width of all data buses.
REQ-002: Parameter TIMEOUT_CYC, default 1024: number of idle cycles mid-packet before the grant is revoked.
REQ-003: Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-004: Port MIB_MASTER_RESET, input, 1: asynchronous, active-high reset.
REQ-005: Ports s0_data/s0_valid/s0_last, inputs, DATA_W/1/1: requester 0 stream (ringbus-bound traffic).
REQ-006: Port s0_ready, output, 1: requester 0 backpressure.
REQ-007: Ports s1_data/s1_valid/s1_last, inputs, DATA_W/1/1: requester 1 stream (turnstile-bound traffic).
REQ-008: Port s1_ready, output, 1: requester 1 backpressure.
REQ-009: Ports m_data/m_valid/m_last, outputs, DATA_W/1/1: merged output stream.
REQ-010: Port m_ready, input, 1: downstream backpressure.
REQ-011: Port o_owner, output, 2: grant state; 00 = none, 01 = s0, 10 = s1.
REQ-012: Port o_timeout_pulse, output, 1: one-cycle strobe when a grant is revoked by timeout.
REQ-013: Port o_timeout_count, output, 16: saturating count of timeouts.

Function
REQ-014: The FSM SHALL have exactly three states: IDLE, GRANT0 and GRANT1.
REQ-015: From IDLE with only sX_valid high, the FSM SHALL move to GRANTX on the next edge.
REQ-016: From IDLE with both valids high, the FSM SHALL grant the requester not recorded in last_served.
REQ-017: last_served SHALL update to X on every transition into GRANTX.
REQ-018: Grants SHALL be packet-atomic: no beats from the other requester are accepted until the granted packet ends or times out.
REQ-019: sX_ready SHALL equal (state==GRANTX) AND (!m_valid OR m_ready), combinationally; it SHALL be 0 in IDLE.
REQ-020: The output SHALL be a single register stage: an input handshake loads m_data/m_last and sets m_valid on the next edge (latency 1 cycle).
REQ-021: m_valid SHALL clear after an output handshake when no new input beat is loaded in the same cycle.
REQ-022: A simultaneous output handshake and input handshake SHALL sustain 1 beat/cycle with no bubble.
REQ-023: m_data and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-024: An accepted input beat with sX_last=1 SHALL return the FSM to IDLE on the same edge that registers the beat.
REQ-025: There SHALL be no idle gap beyond the one IDLE cycle between packets.
REQ-026: A single-beat packet (valid and last on the first beat) SHALL be legal.
REQ-027: A 16-bit idle counter SHALL clear on every input handshake and on every state change, and SHALL increment each GRANTX cycle without an input handshake.
REQ-028: While m_valid=1 and m_ready=0, the idle counter SHALL hold, so that downstream stall never causes a timeout.
REQ-029: When the idle counter reaches TIMEOUT_CYC-1 and would increment, the FSM SHALL return to IDLE.
REQ-030: On that timeout, o_timeout_pulse SHALL be high for exactly 1 cycle and o_timeout_count SHALL increment, saturating at 16'hFFFF.
REQ-031: A timeout SHALL NOT synthesise an m_last; the truncated packet is the upstream owner's fault.
REQ-032: An already-registered output beat SHALL still drain after a timeout.
REQ-033: o_owner SHALL be a registered decode of state.

Reset
REQ-034: While MIB_MASTER_RESET=1, the state SHALL be IDLE and last_served SHALL be 1, so that s0 wins the first tie.
REQ-035: While MIB_MASTER_RESET=1, m_valid, m_last, m_data, o_owner, o_timeout_pulse, o_timeout_count and the idle counter SHALL all be 0, and s0_ready/s1_ready SHALL be 0.
REQ-036: Reset asserted mid-packet SHALL drop all in-flight state asynchronously, with no partial beat emitted after deassertion.
REQ-037: After reset deasserts, the first grant SHALL occur no earlier than the first edge on which a valid is sampled high.

Verification
REQ-038: Tie with packets queued: s0 and s1 valid together on the first cycle after reset, 3-beat packets, m_ready=1 -> s0 beats emitted first (o_owner=01), then 1 IDLE cycle, then s1 beats (o_owner=10).
REQ-039: Repeated contention: four consecutive contended packets -> order s0, s1, s0, s1.
REQ-040: Throughput: s0 sends 8 beats valid continuously, m_ready=1 -> m_valid high 8 consecutive cycles starting 1 cycle after grant; m_last only on beat 8; data matches in order.
REQ-041: Backpressure: m_ready toggles 1/0 every cycle during a 5-beat packet -> all 5 beats delivered, each held stable while stalled; no loss or duplication.
REQ-042: Timeout: TIMEOUT_CYC=16, s1 sends 2 beats (no last) then drops valid -> grant revoked 16 idle cycles later, o_timeout_pulse for 1 cycle, o_timeout_count=1, s0 granted next.
REQ-043: Stall immunity: same as REQ-042 but m_ready=0 for 40 cycles while m_valid=1 -> no timeout.
REQ-044: Reset mid-packet: assert MIB_MASTER_RESET on beat 2 of 4 -> all outputs 0 immediately; after release, s1 and s0 valid together -> s0 granted first.

Source files
------------

// File: rtl/stream_pkt_arbiter.sv
// stream_pkt_arbiter: two-requester packet-atomic stream arbiter with a single
// output register stage, round-robin tie break and a mid-packet idle timeout.
module stream_pkt_arbiter #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              MIB_MASTER_RESET,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_valid,
  input  logic              s0_last,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_valid,
  input  logic              s1_last,
  output logic              s1_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic [1:0]        o_owner,
  output logic              o_timeout_pulse,
  output logic [15:0]       o_timeout_count
);

  // State encoding doubles as the o_owner code.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT_CYC - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_served;   // 0 = s0 served last, 1 = s1 served last
  logic [DATA_W-1:0]   r_m_data;
  logic                r_m_valid;
  logic                r_m_last;
  logic [1:0]          r_owner;
  logic                r_timeout_pulse;
  logic [15:0]         r_timeout_count;
  logic [15:0]         r_idle_cnt;
  logic [1:0]          w_owner_nxt;

  // A held output beat with no downstream ready freezes the whole pipe.
  wire w_stall   = r_m_valid && !m_ready;
  wire w_hs0     = s0_valid && s0_ready;
  wire w_hs1     = s1_valid && s1_ready;
  wire w_in_hs   = w_hs0 || w_hs1;
  wire w_in_last = w_hs0 ? s0_last : s1_last;
  wire w_timeout = (r_state != IDLE) && !w_in_hs && !w_stall &&
                   (r_idle_cnt == IDLE_LIMIT);

  // State register and round-robin history.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge MIB_MASTER_RESET) begin
    if (MIB_MASTER_RESET) begin
      r_state       <= IDLE;
      r_last_served <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_state_nxt == GRANT0) r_last_served <= 1'b0;
      if (r_state == IDLE && w_state_nxt == GRANT1) r_last_served <= 1'b1;
    end
  end

  // Next-state: arbitrate from IDLE, release on accepted last beat or timeout.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (s0_valid && (!s1_valid || r_last_served)) w_state_nxt = GRANT0;
        else if (s1_valid)                            w_state_nxt = GRANT1;
      end
      GRANT0, GRANT1: begin
        if ((w_in_hs && w_in_last) || w_timeout) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs: per-requester ready and the owner code to be registered.
  always_comb begin
    s0_ready    = (r_state == GRANT0) && !w_stall;
    s1_ready    = (r_state == GRANT1) && !w_stall;
    w_owner_nxt = w_state_nxt;
  end

  // Output register stage: load on input handshake, clear valid once drained.
  always_ff @(posedge clk or posedge MIB_MASTER_RESET) begin
    if (MIB_MASTER_RESET) begin
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else if (w_in_hs) begin
      r_m_data  <= w_hs0 ? s0_data : s1_data;
      r_m_last  <= w_in_last;
      r_m_valid <= 1'b1;
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  // Idle counter: cleared by traffic or state change, frozen during stall.
  always_ff @(posedge clk or posedge MIB_MASTER_RESET) begin
    if (MIB_MASTER_RESET) begin
      r_idle_cnt <= '0;
    end else if (w_in_hs || (w_state_nxt != r_state)) begin
      r_idle_cnt <= '0;
    end else if (r_state != IDLE && !w_stall) begin
      r_idle_cnt <= r_idle_cnt + 16'd1;
    end
  end

  // Owner register and timeout reporting.
  always_ff @(posedge clk or posedge MIB_MASTER_RESET) begin
    if (MIB_MASTER_RESET) begin
      r_owner         <= 2'b00;
      r_timeout_pulse <= 1'b0;
      r_timeout_count <= '0;
    end else begin
      r_owner         <= w_owner_nxt;
      r_timeout_pulse <= w_timeout;
      if (w_timeout && r_timeout_count != 16'hFFFF)
        r_timeout_count <= r_timeout_count + 16'd1;
    end
  end

  assign m_data          = r_m_data;
  assign m_valid         = r_m_valid;
  assign m_last          = r_m_last;
  assign o_owner         = r_owner;
  assign o_timeout_pulse = r_timeout_pulse;
  assign o_timeout_count = r_timeout_count;

endmodule

// File: tb/tb_stream_pkt_arbiter.sv
// tb_stream_pkt_arbiter: directed table vectors plus hand-written multi-cycle
// sequences for contention, throughput, backpressure, timeout and reset.
module tb_stream_pkt_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s0_data, s1_data, m_data;
  logic          s0_valid, s0_last, s0_ready;
  logic          s1_valid, s1_last, s1_ready;
  logic          m_valid, m_last, m_ready;
  logic [1:0]    o_owner;
  logic          o_timeout_pulse;
  logic [15:0]   o_timeout_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stream_pkt_arbiter #(.DATA_W(DW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .MIB_MASTER_RESET(rst),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .o_owner(o_owner), .o_timeout_pulse(o_timeout_pulse),
    .o_timeout_count(o_timeout_count)
  );

  typedef struct {
    logic          s0v, s0l;
    logic [DW-1:0] s0d;
    logic          s1v, s1l;
    logic [DW-1:0] s1d;
    logic          mr;
    logic          e_s0r, e_s1r, e_mv, e_ml;
    logic [DW-1:0] e_md;
    logic [1:0]    e_own;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s0_valid = 0; s0_last = 0; s0_data = '0;
    s1_valid = 0; s1_last = 0; s1_data = '0;
    m_ready  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic s0v, s0l, input logic [DW-1:0] s0d,
                              input logic s1v, s1l, input logic [DW-1:0] s1d,
                              input logic mr, e_s0r, e_s1r, e_mv, e_ml,
                              input logic [DW-1:0] e_md, input logic [1:0] e_own);
    vec_t v;
    v.s0v = s0v; v.s0l = s0l; v.s0d = s0d;
    v.s1v = s1v; v.s1l = s1l; v.s1d = s1d;
    v.mr = mr; v.e_s0r = e_s0r; v.e_s1r = e_s1r;
    v.e_mv = e_mv; v.e_ml = e_ml; v.e_md = e_md; v.e_own = e_own;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    int            k, n0, n1;
    logic          hs0, hs1, prev_stall, s0_done;
    logic [DW-1:0] prev_d;
    logic          prev_l;

    // Tie on the first post-reset cycle: s0 packet first, one IDLE, then s1.
    vecs[0] = mk(1,0,32'hA0, 1,0,32'hB0, 1, 0,0,0,0,32'h0, 2'b00);
    vecs[1] = mk(1,0,32'hA0, 1,0,32'hB0, 1, 1,0,0,0,32'h0, 2'b01);
    vecs[2] = mk(1,0,32'hA1, 1,0,32'hB0, 1, 1,0,1,0,32'hA0, 2'b01);
    vecs[3] = mk(1,1,32'hA2, 1,0,32'hB0, 1, 1,0,1,0,32'hA1, 2'b01);
    vecs[4] = mk(0,0,32'h0,  1,0,32'hB0, 1, 0,0,1,1,32'hA2, 2'b00);
    vecs[5] = mk(0,0,32'h0,  1,0,32'hB0, 1, 0,1,0,0,32'h0, 2'b10);
    vecs[6] = mk(0,0,32'h0,  1,0,32'hB1, 1, 0,1,1,0,32'hB0, 2'b10);
    vecs[7] = mk(0,0,32'h0,  1,1,32'hB2, 1, 0,1,1,0,32'hB1, 2'b10);
    vecs[8] = mk(0,0,32'h0,  0,0,32'h0,  1, 0,0,1,1,32'hB2, 2'b00);
    vecs[9] = mk(0,0,32'h0,  0,0,32'h0,  1, 0,0,0,0,32'h0, 2'b00);

    // Reset values, with valids high to show ready stays low under reset.
    rst = 1'b1; m_ready = 1'b1;
    s0_valid = 1; s0_last = 0; s0_data = 32'h11;
    s1_valid = 1; s1_last = 0; s1_data = 32'h22;
    tick();
    check("rst_s0_ready", s0_ready, 0);
    check("rst_s1_ready", s1_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_owner", o_owner, 0);
    check("rst_pulse", o_timeout_pulse, 0);
    check("rst_count", o_timeout_count, 0);

    // Table-driven tie test.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      s0_valid = vecs[i].s0v; s0_last = vecs[i].s0l; s0_data = vecs[i].s0d;
      s1_valid = vecs[i].s1v; s1_last = vecs[i].s1l; s1_data = vecs[i].s1d;
      m_ready  = vecs[i].mr;
      #1;
      check($sformatf("tie[%0d]_s0_ready", i), s0_ready, vecs[i].e_s0r);
      check($sformatf("tie[%0d]_s1_ready", i), s1_ready, vecs[i].e_s1r);
      check($sformatf("tie[%0d]_m_valid", i), m_valid, vecs[i].e_mv);
      check($sformatf("tie[%0d]_owner", i), o_owner, vecs[i].e_own);
      if (vecs[i].e_mv) begin
        check($sformatf("tie[%0d]_m_data", i), m_data, vecs[i].e_md);
        check($sformatf("tie[%0d]_m_last", i), m_last, vecs[i].e_ml);
      end
      tick();
    end

    // Repeated contention: single-beat packets from both sides, alternating order.
    do_reset();
    s0_valid = 1; s0_last = 1; s1_valid = 1; s1_last = 1;
    n0 = 0; n1 = 0; got_d.delete();
    for (int cyc = 0; cyc < 40 && got_d.size() < 4; cyc++) begin
      s0_data = 32'h100 + n0;
      s1_data = 32'h200 + n1;
      #1;
      hs0 = s0_valid && s0_ready;
      hs1 = s1_valid && s1_ready;
      if (m_valid && m_ready) got_d.push_back(m_data);
      tick();
      n0 += int'(hs0);
      n1 += int'(hs1);
    end
    s0_valid = 0; s1_valid = 0;
    check("rr_beat_count", got_d.size(), 4);
    for (int i = 0; i < got_d.size() && i < 4; i++)
      check($sformatf("rr_order[%0d]", i), got_d[i],
            (i % 2 == 0) ? 32'h100 + i / 2 : 32'h200 + i / 2);

    // Throughput: 8 continuous beats, no bubble, last only on beat 8.
    do_reset();
    k = 0;
    for (int cyc = 0; cyc <= 10; cyc++) begin
      s0_valid = (k < 8);
      s0_data  = 32'hC0 + k;
      s0_last  = (k == 7);
      #1;
      if (cyc >= 1 && cyc <= 8) check($sformatf("tp_ready[%0d]", cyc), s0_ready, 1);
      check($sformatf("tp_m_valid[%0d]", cyc), m_valid, (cyc >= 2 && cyc <= 9));
      if (cyc >= 2 && cyc <= 9) begin
        check($sformatf("tp_m_data[%0d]", cyc), m_data, 32'hC0 + (cyc - 2));
        check($sformatf("tp_m_last[%0d]", cyc), m_last, (cyc == 9));
      end
      hs0 = s0_valid && s0_ready;
      tick();
      k += int'(hs0);
    end
    check("tp_beats_sent", k, 8);

    // Backpressure: m_ready toggles every cycle over a 5-beat packet.
    do_reset();
    k = 0; got_d.delete(); got_l.delete(); prev_stall = 0; prev_d = '0; prev_l = 0;
    for (int cyc = 0; cyc < 40 && got_d.size() < 5; cyc++) begin
      s0_valid = (k < 5);
      s0_data  = 32'hD0 + k;
      s0_last  = (k == 4);
      m_ready  = (cyc % 2 == 0);
      #1;
      if (prev_stall) begin
        check($sformatf("bp_hold_data[%0d]", cyc), m_data, prev_d);
        check($sformatf("bp_hold_last[%0d]", cyc), m_last, prev_l);
      end
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
      end
      prev_stall = m_valid && !m_ready;
      prev_d = m_data; prev_l = m_last;
      hs0 = s0_valid && s0_ready;
      tick();
      k += int'(hs0);
    end
    s0_valid = 0; m_ready = 1;
    check("bp_beat_count", got_d.size(), 5);
    for (int i = 0; i < got_d.size() && i < 5; i++) begin
      check($sformatf("bp_data[%0d]", i), got_d[i], 32'hD0 + i);
      check($sformatf("bp_last[%0d]", i), got_l[i], (i == 4));
    end

    // Timeout: s1 sends 2 beats and goes quiet; revoked after 16 idle cycles.
    do_reset();
    k = 0; s0_done = 0;
    for (int cyc = 0; cyc <= 21; cyc++) begin
      s1_valid = (k < 2);
      s1_data  = 32'hE0 + k;
      s1_last  = 0;
      s0_valid = (cyc >= 19) && !s0_done;
      s0_data  = 32'hF0;
      s0_last  = 1;
      #1;
      if (cyc == 2) begin
        check("to_beat0_valid", m_valid, 1);
        check("to_beat0_data", m_data, 32'hE0);
      end
      if (cyc == 3) begin
        check("to_beat1_data", m_data, 32'hE1);
        check("to_beat1_last", m_last, 0);
      end
      if (cyc == 4) check("to_drained", m_valid, 0);
      if (cyc == 17 || cyc == 18) begin
        check($sformatf("to_owner_held[%0d]", cyc), o_owner, 2'b10);
        check($sformatf("to_no_pulse[%0d]", cyc), o_timeout_pulse, 0);
      end
      if (cyc == 19) begin
        check("to_owner_idle", o_owner, 2'b00);
        check("to_pulse", o_timeout_pulse, 1);
        check("to_count", o_timeout_count, 1);
        check("to_no_fake_beat", m_valid, 0);
      end
      if (cyc == 20) begin
        check("to_pulse_once", o_timeout_pulse, 0);
        check("to_owner_s0", o_owner, 2'b01);
        check("to_s0_ready", s0_ready, 1);
        check("to_count_hold", o_timeout_count, 1);
      end
      hs0 = s0_valid && s0_ready;
      hs1 = s1_valid && s1_ready;
      tick();
      k += int'(hs1);
      if (hs0) s0_done = 1;
    end
    s0_valid = 0;

    // Stall immunity: 40 cycles of m_ready=0 with a held beat never time out.
    do_reset();
    k = 0;
    for (int cyc = 0; cyc <= 43; cyc++) begin
      s1_valid = (k < 2);
      s1_data  = 32'hE0 + k;
      s1_last  = 0;
      m_ready  = !(cyc >= 3 && cyc < 43);
      #1;
      if (cyc >= 3 && cyc <= 42) begin
        check($sformatf("st_owner[%0d]", cyc), o_owner, 2'b10);
        check($sformatf("st_no_pulse[%0d]", cyc), o_timeout_pulse, 0);
      end
      if (cyc == 42) begin
        check("st_data_held", m_data, 32'hE1);
        check("st_count_zero", o_timeout_count, 0);
      end
      if (cyc == 43) check("st_drain_valid", m_valid, 1);
      hs1 = s1_valid && s1_ready;
      tick();
      k += int'(hs1);
    end
    m_ready = 1;

    // Reset mid-packet on beat 2 of 4, then a tie goes to s0.
    do_reset();
    k = 0;
    for (int cyc = 0; cyc <= 2; cyc++) begin
      s0_valid = 1; s0_data = 32'h50 + k; s0_last = 0;
      #1;
      hs0 = s0_valid && s0_ready;
      if (cyc < 2) begin
        tick();
        k += int'(hs0);
      end
    end
    check("mr_beat_in_flight", m_valid, 1);
    rst = 1'b1;
    #1;
    check("mr_m_valid", m_valid, 0);
    check("mr_m_data", m_data, 0);
    check("mr_m_last", m_last, 0);
    check("mr_owner", o_owner, 0);
    check("mr_s0_ready", s0_ready, 0);
    check("mr_count", o_timeout_count, 0);
    tick();
    s0_valid = 1; s0_data = 32'h77; s0_last = 1;
    s1_valid = 1; s1_data = 32'h88; s1_last = 1;
    tick();
    rst = 1'b0;
    #1;
    check("mr_rel_m_valid", m_valid, 0);
    check("mr_rel_owner", o_owner, 0);
    tick();
    #1;
    check("mr_tie_owner", o_owner, 2'b01);
    check("mr_tie_s0_ready", s0_ready, 1);
    check("mr_tie_s1_ready", s1_ready, 0);
    check("mr_tie_no_stale", m_valid, 0);
    tick();
    #1;
    check("mr_first_valid", m_valid, 1);
    check("mr_first_data", m_data, 32'h77);
    s0_valid = 0; s1_valid = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
